seg7_scan_capture: RTL and testbench

SEG7_SCAN_CAPTURE -- requirements
Module: seg7_scan_capture

---
 rtl/seg7_scan_capture.sv | 149 ++++++++++++++
 tb/tb_seg7_scan_capture.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_capture.sv
// Captures a multiplexed 4-digit 7-segment scan into a 16-bit BCD frame.
// Each digit must be seen stable for STABLE_CNT samples before it is committed.
module seg7_scan_capture #(
  parameter int STABLE_CNT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SAMPLE_EN,
  input  logic [3:0]  AN,
  input  logic [6:0]  SEG,
  output logic [15:0] DIGITS,
  output logic        VALID,
  output logic        FRAME,
  output logic        ERR,
  output logic [3:0]  BAD_DIGIT
);

  typedef enum logic [1:0] {IDLE, COUNT, LOCKED} state_t;

  localparam logic [3:0] STABLE = 4'(STABLE_CNT);

  state_t      state, state_n;
  logic [3:0]  run_cnt, run_cnt_n;
  logic [10:0] prev, prev_n;
  logic [3:0]  mask, mask_n;
  logic [15:0] shadow, shadow_n;
  logic [3:0]  shadow_bad, bad_n;
  logic        one_hot, same, commit, frame_done;
  logic [3:0]  code;
  logic        code_bad;
  logic [1:0]  idx;

  assign one_hot    = (AN != 4'd0) && ((AN & (AN - 4'd1)) == 4'd0);
  assign same       = ({AN, SEG} == prev);
  assign frame_done = commit && (mask_n == 4'hF);

  always_comb begin
    code     = 4'hE;
    code_bad = 1'b0;
    case (SEG)
      7'b1111110: code = 4'd0;
      7'b0110000: code = 4'd1;
      7'b1101101: code = 4'd2;
      7'b1111001: code = 4'd3;
      7'b0110011: code = 4'd4;
      7'b1011011: code = 4'd5;
      7'b1011111: code = 4'd6;
      7'b1110010: code = 4'd7;
      7'b1111111: code = 4'd8;
      7'b1111011: code = 4'd9;
      7'b0000000: code = 4'hF;
      default:    code_bad = 1'b1;
    endcase
  end

  always_comb begin
    idx = 2'd0;
    case (AN)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  // A fresh one-hot sample restarts the run; with STABLE_CNT=1 it commits immediately.
  always_comb begin
    state_n   = state;
    run_cnt_n = run_cnt;
    prev_n    = prev;
    commit    = 1'b0;
    if (SAMPLE_EN) begin
      if (!one_hot) begin
        state_n   = IDLE;
        run_cnt_n = 4'd0;
      end else if (state != IDLE && same) begin
        if (state == COUNT) begin
          run_cnt_n = run_cnt + 4'd1;
          if (run_cnt + 4'd1 >= STABLE) begin
            commit  = 1'b1;
            state_n = LOCKED;
          end
        end
      end else begin
        prev_n    = {AN, SEG};
        run_cnt_n = 4'd1;
        if (STABLE == 4'd1) begin
          commit  = 1'b1;
          state_n = LOCKED;
        end else begin
          state_n = COUNT;
        end
      end
    end
  end

  always_comb begin
    shadow_n = shadow;
    bad_n    = shadow_bad;
    mask_n   = mask;
    if (commit) begin
      shadow_n[{idx, 2'b00} +: 4] = code;
      bad_n[idx]                  = code_bad;
      mask_n[idx]                 = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      run_cnt <= 4'd0;
      prev    <= 11'd0;
    end else begin
      state   <= state_n;
      run_cnt <= run_cnt_n;
      prev    <= prev_n;
    end
  end

  // The completing digit is taken from shadow_n so it lands in the same frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mask       <= 4'd0;
      shadow     <= 16'd0;
      shadow_bad <= 4'd0;
      DIGITS     <= 16'd0;
      BAD_DIGIT  <= 4'd0;
      ERR        <= 1'b0;
      VALID      <= 1'b0;
      FRAME      <= 1'b0;
    end else begin
      FRAME  <= 1'b0;
      shadow <= shadow_n;
      if (frame_done) begin
        DIGITS     <= shadow_n;
        BAD_DIGIT  <= bad_n;
        ERR        <= |bad_n;
        VALID      <= 1'b1;
        FRAME      <= 1'b1;
        mask       <= 4'd0;
        shadow_bad <= 4'd0;
      end else begin
        mask       <= mask_n;
        shadow_bad <= bad_n;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture; expected frames are queued when the
// completing sample is driven and checked when FRAME is observed.
module tb_seg7_scan_capture;

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  bad;
  } exp_t;

  localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101,
                         S3 = 7'b1111001, S4 = 7'b0110011, S5 = 7'b1011011,
                         S6 = 7'b1011111, S7 = 7'b1110010, S8 = 7'b1111111,
                         S9 = 7'b1111011, SBLANK = 7'b0000000, SBAD = 7'b1000001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sampleEn = 1'b0;
  logic [3:0]  an = 4'd0;
  logic [6:0]  seg = 7'd0;
  logic [15:0] digits;
  logic        valid, frame, err;
  logic [3:0]  badDigit;

  exp_t        expQ[$];
  logic [15:0] curDigits = 16'd0;
  logic [3:0]  curBad = 4'd0;
  logic        curValid = 1'b0;
  int          totalChecks = 0;
  int          passCount = 0;
  int          failCount = 0;

  seg7_scan_capture #(.STABLE_CNT(4)) dut (
    .CLK(clk), .RST(rst), .SAMPLE_EN(sampleEn), .AN(an), .SEG(seg),
    .DIGITS(digits), .VALID(valid), .FRAME(frame), .ERR(err), .BAD_DIGIT(badDigit)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    totalChecks++;
    assert (obs === expv) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Every cycle: FRAME matches the queue, outputs match the last expected frame.
  task automatic checkOutput();
    exp_t e;
    logic expFrame;
    expFrame = 1'b0;
    if (expQ.size() > 0) begin
      e         = expQ.pop_front();
      curDigits = e.digits;
      curBad    = e.bad;
      curValid  = 1'b1;
      expFrame  = 1'b1;
    end
    checkVal("frame", {15'd0, frame}, {15'd0, expFrame});
    checkVal("digits", digits, curDigits);
    checkVal("bad_digit", {12'd0, badDigit}, {12'd0, curBad});
    checkVal("err", {15'd0, err}, {15'd0, |curBad});
    checkVal("valid", {15'd0, valid}, {15'd0, curValid});
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [6:0] s, input logic en,
                               input logic pushExp, input logic [15:0] d, input logic [3:0] b);
    exp_t e;
    @(negedge clk);
    an       = a;
    seg      = s;
    sampleEn = en;
    if (pushExp) begin
      e.digits = d;
      e.bad    = b;
      expQ.push_back(e);
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic scanDigit(input logic [3:0] a, input logic [6:0] s, input int n,
                           input logic frameOnLast, input logic [15:0] d, input logic [3:0] b);
    for (int i = 0; i < n; i++)
      applyStimulus(a, s, 1'b1, frameOnLast && (i == n - 1), d, b);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst      = 1'b1;
    sampleEn = 1'b1;
    an       = 4'b0001;
    seg      = S1;
    @(posedge clk);
    #1;
    expQ.delete();
    curDigits = 16'd0;
    curBad    = 4'd0;
    curValid  = 1'b0;
    checkOutput();
    @(negedge clk);
    rst      = 1'b0;
    sampleEn = 1'b0;
  endtask

  initial begin
    doReset();

    // Basic in-order scan.
    scanDigit(4'b0001, S1, 4, 1'b0, 16'h0, 4'h0);
    scanDigit(4'b0010, S2, 4, 1'b0, 16'h0, 4'h0);
    scanDigit(4'b0100, S3, 4, 1'b0, 16'h0, 4'h0);
    scanDigit(4'b1000, S4, 4, 1'b1, 16'h4321, 4'h0);

    // Digit 2 seen only 3 times: no frame until it gets a full run.
    scanDigit(4'b0001, S5, 4, 1'b0, 16'h0, 4'h0);
    scanDigit(4'b0010, S6, 4, 1'b0, 16'h0, 4'h0);
    scanDigit(4'b0100, S7, 3, 1'b0, 16'h0, 4'h0);
    scanDigit(4'b1000, S8, 4, 1'b0, 16'h0, 4'h0);
    scanDigit(4'b0100, S7, 4, 1'b1, 16'h8765, 4'h0);

    // Invalid pattern on digit 0, then a clean frame of zeros.
    scanDigit(4'b0001, SBAD, 4, 1'b0, 16'h0, 4'h0);
    scanDigit(4'b0010, S9, 4, 1'b0, 16'h0, 4'h0);
    scanDigit(4'b0100, S9, 4, 1'b0, 16'h0, 4'h0);
    scanDigit(4'b1000, S9, 4, 1'b1, 16'h999E, 4'b0001);
    scanDigit(4'b0001, S0, 4, 1'b0, 16'h0, 4'h0);
    scanDigit(4'b0010, S0, 4, 1'b0, 16'h0, 4'h0);
    scanDigit(4'b0100, S0, 4, 1'b0, 16'h0, 4'h0);
    scanDigit(4'b1000, S0, 4, 1'b1, 16'h0000, 4'h0);

    // Non-one-hot interruptions restart the run; disabled cycles are ignored.
    scanDigit(4'b1000, S1, 4, 1'b0, 16'h0, 4'h0);
    scanDigit(4'b0100, S2, 4, 1'b0, 16'h0, 4'h0);
    scanDigit(4'b0010, S3, 2, 1'b0, 16'h0, 4'h0);
    applyStimulus(4'b0000, S3, 1'b1, 1'b0, 16'h0, 4'h0);
    scanDigit(4'b0010, S3, 4, 1'b0, 16'h0, 4'h0);
    scanDigit(4'b0001, S4, 2, 1'b0, 16'h0, 4'h0);
    applyStimulus(4'b0011, S4, 1'b1, 1'b0, 16'h0, 4'h0);
    scanDigit(4'b0001, S4, 3, 1'b0, 16'h0, 4'h0);
    for (int i = 0; i < 3; i++)
      applyStimulus(4'b0011, SBAD, 1'b0, 1'b0, 16'h0, 4'h0);
    applyStimulus(4'b0001, S4, 1'b1, 1'b1, 16'h1234, 4'h0);

    // Long hold on a blank digit 3 must commit only once.
    scanDigit(4'b0001, S2, 4, 1'b0, 16'h0, 4'h0);
    scanDigit(4'b0010, S1, 4, 1'b0, 16'h0, 4'h0);
    scanDigit(4'b0100, S0, 4, 1'b0, 16'h0, 4'h0);
    scanDigit(4'b1000, SBLANK, 4, 1'b1, 16'hF012, 4'h0);
    scanDigit(4'b1000, SBLANK, 16, 1'b0, 16'h0, 4'h0);
    scanDigit(4'b0001, S9, 4, 1'b0, 16'h0, 4'h0);
    scanDigit(4'b0010, S9, 4, 1'b0, 16'h0, 4'h0);
    scanDigit(4'b0100, S9, 4, 1'b0, 16'h0, 4'h0);
    scanDigit(4'b1000, S3, 4, 1'b1, 16'h3999, 4'h0);

    // Reset mid-frame discards the partial capture.
    scanDigit(4'b0001, S1, 4, 1'b0, 16'h0, 4'h0);
    scanDigit(4'b0010, S2, 4, 1'b0, 16'h0, 4'h0);
    scanDigit(4'b0100, S3, 4, 1'b0, 16'h0, 4'h0);
    doReset();
    scanDigit(4'b1000, S5, 4, 1'b0, 16'h0, 4'h0);
    scanDigit(4'b0001, S8, 4, 1'b0, 16'h0, 4'h0);
    scanDigit(4'b0010, S7, 4, 1'b0, 16'h0, 4'h0);
    scanDigit(4'b0100, S6, 4, 1'b1, 16'h5678, 4'h0);
    applyStimulus(4'b0000, SBLANK, 1'b0, 1'b0, 16'h0, 4'h0);

    checkVal("queue_drained", 16'(expQ.size()), 16'd0);
    $display("%0d/%0d checks passed", passCount, totalChecks);
    $finish;
  end

endmodule
